// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the restoring divider
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-and-trial-subtract iteration
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;
  logic             negative;

  // One extra guard bit keeps the sign of the trial difference unambiguous.
  always_comb begin
    r_shift  = {r, q[WIDTH-1]};
    trial    = r_shift - {2'b00, d};
    negative = trial[WIDTH+1];
    r_next   = negative ? r_shift[WIDTH:0] : trial[WIDTH:0];
    q_next   = {q[WIDTH-2:0], ~negative};
  end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one bit per clock
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   r_next;
  logic             last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  assign last_step = (count == CNT_W'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              d_reg <= divisor;
              q_reg <= dividend;
              r_reg <= '0;
              count <= '0;
            end else begin
              // Zero divisor bypasses RUN and reports a saturated quotient.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + 1'b1;
          if (last_step) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard and vector-table bench for restoring_divider
module tb_restoring_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  vec_t sb[$];
  vec_t vecs[6];

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == 0) begin
      v.q = '1;
      v.r = a;
      v.dbz = 1'b1;
    end else begin
      v.q = a / b;
      v.r = a % b;
      v.dbz = 1'b0;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    vec_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_quotient", quotient, e.q);
        chk("sb_remainder", remainder, e.r);
        chk("sb_div_by_zero", div_by_zero, e.dbz);
      end
    end
  end

  // Called at #1 after an edge with the DUT in IDLE; returns likewise.
  task automatic do_op(input vec_t e, input bit disturb);
    int n;
    int busy_n;
    sb.push_back(e);
    dividend = e.a;
    divisor  = e.b;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (disturb) begin
        start    = (n < 4);
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency_edges", n, (e.b == 0) ? 1 : W + 1);
    chk("busy_cycles", busy_n, (e.b == 0) ? 0 : W);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    vec_t e;
    int   ndone;
    int   last;
    int   guard;

    vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dbz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dbz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dbz: 1'b0};
    vecs[4] = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37, dbz: 1'b1};
    vecs[5] = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,  dbz: 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i], 1'b0);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_quotient", quotient, vecs[i].q);
      chk("hold_remainder", remainder, vecs[i].r);
      chk("hold_div_by_zero", div_by_zero, vecs[i].dbz);
    end

    for (int i = 0; i < 6; i++) begin
      e = model(W'($urandom), (i == 2) ? 8'd0 : W'($urandom_range(1, 255)));
      do_op(e, 1'b0);
    end

    // Abort during the 4th RUN cycle; no done may follow.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_by_zero", div_by_zero, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(model(8'd200, 8'd13), 1'b0);
    chk("after_abort_quotient", quotient, 15);
    chk("after_abort_remainder", remainder, 5);

    do_op(model(8'd100, 8'd7), 1'b1);
    chk("ignored_start_quotient", quotient, 14);
    chk("ignored_start_remainder", remainder, 2);

    sb.push_back(model(8'd77, 8'd5));
    dividend = 8'd77;
    divisor  = 8'd5;
    start    = 1'b1;
    ndone    = 0;
    last     = -1;
    guard    = 0;
    while (ndone < 3 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
      if (done) begin
        ndone++;
        if (last >= 0) chk("b2b_spacing", cyc - last, W + 2);
        last = cyc;
        if (ndone < 3) sb.push_back(model(8'd77, 8'd5));
        else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_done_count", ndone, 3);

    repeat (W + 4) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("idle_at_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no summary expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
